// File: rtl/reg_bank_ab.sv
// Integer register file (x0 hardwired to zero) with A/B operand latches for the multicycle RV64 core.
// Read ports are combinational from the flop array; latch loads see same-cycle writes through forwarding.
module reg_bank_ab #(
    parameter int DATA_W = 64,
    parameter int N_REGS = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              BANCO_WIRE,
    input  logic              LOAD_A,
    input  logic              LOAD_B,
    input  logic [4:0]        IR19_15,
    input  logic [4:0]        IR24_20,
    input  logic [4:0]        IR11_7,
    input  logic [DATA_W-1:0] WRITE_DATA,
    input  logic [4:0]        DBG_ADDR,
    output logic [DATA_W-1:0] RS1_DATA,
    output logic [DATA_W-1:0] RS2_DATA,
    output logic [DATA_W-1:0] REG_A_OUT,
    output logic [DATA_W-1:0] REG_B_OUT,
    output logic [DATA_W-1:0] DBG_DATA,
    output logic [31:0]       WRITE_COUNT
);

    logic [DATA_W-1:0] regs_q [N_REGS];
    logic [DATA_W-1:0] regs_d [N_REGS];
    logic [DATA_W-1:0] reg_a_q, reg_a_d;
    logic [DATA_W-1:0] reg_b_q, reg_b_d;
    logic [31:0]       write_count_q, write_count_d;
    logic              wr_en;

    assign wr_en = BANCO_WIRE && (IR11_7 != 5'd0);

    function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
        return (addr == 5'd0) ? '0 : regs_q[addr];
    endfunction

    // Latch source: the value rd will hold after this edge.
    function automatic logic [DATA_W-1:0] operand(input logic [4:0] addr);
        if (wr_en && (IR11_7 == addr)) begin
            return WRITE_DATA;
        end
        return read_port(addr);
    endfunction

    always_comb begin
        regs_d        = regs_q;
        write_count_d = write_count_q;
        if (wr_en) begin
            regs_d[IR11_7] = WRITE_DATA;
            write_count_d  = write_count_q + 32'd1;
        end
        regs_d[0] = '0;
    end

    always_comb begin
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        if (LOAD_A) begin
            reg_a_d = operand(IR19_15);
        end
        if (LOAD_B) begin
            reg_b_d = operand(IR24_20);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
            reg_a_q       <= '0;
            reg_b_q       <= '0;
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            reg_a_q       <= reg_a_d;
            reg_b_q       <= reg_b_d;
            write_count_q <= write_count_d;
        end
    end

    assign RS1_DATA    = read_port(IR19_15);
    assign RS2_DATA    = read_port(IR24_20);
    assign DBG_DATA    = read_port(DBG_ADDR);
    assign REG_A_OUT   = reg_a_q;
    assign REG_B_OUT   = reg_b_q;
    assign WRITE_COUNT = write_count_q;

endmodule

// File: tb/tb_reg_bank_ab.sv
// Bench for reg_bank_ab: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against an array-based model of the register file and latches.
module tb_reg_bank_ab;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BANCO_WIRE;
    logic        LOAD_A;
    logic        LOAD_B;
    logic [4:0]  IR19_15;
    logic [4:0]  IR24_20;
    logic [4:0]  IR11_7;
    logic [63:0] WRITE_DATA;
    logic [4:0]  DBG_ADDR;
    logic [63:0] RS1_DATA;
    logic [63:0] RS2_DATA;
    logic [63:0] REG_A_OUT;
    logic [63:0] REG_B_OUT;
    logic [63:0] DBG_DATA;
    logic [31:0] WRITE_COUNT;

    reg_bank_ab #(.DATA_W(64), .N_REGS(32)) dut (
        .CLK(CLK), .RESET(RESET), .BANCO_WIRE(BANCO_WIRE), .LOAD_A(LOAD_A), .LOAD_B(LOAD_B),
        .IR19_15(IR19_15), .IR24_20(IR24_20), .IR11_7(IR11_7), .WRITE_DATA(WRITE_DATA),
        .DBG_ADDR(DBG_ADDR), .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .REG_A_OUT(REG_A_OUT),
        .REG_B_OUT(REG_B_OUT), .DBG_DATA(DBG_DATA), .WRITE_COUNT(WRITE_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;
    bit check_en = 1'b0;

    // Model state: what an architectural register file holds after each edge.
    logic [63:0] m_regs [32];
    logic [63:0] m_a, m_b;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_read(input logic [4:0] a);
        return (a == 0) ? 64'd0 : m_regs[a];
    endfunction

    always @(posedge CLK) begin
        logic [63:0] next_a, next_b;
        if (RESET) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
            m_a   = 64'd0;
            m_b   = 64'd0;
            m_cnt = 32'd0;
        end else begin
            next_a = m_a;
            next_b = m_b;
            if (BANCO_WIRE && IR11_7 != 0) begin
                m_regs[IR11_7] = WRITE_DATA;
                m_cnt          = m_cnt + 32'd1;
            end
            // Loads happen after the write, so a same-cycle write is seen by the latches.
            if (LOAD_A) next_a = m_read(IR19_15);
            if (LOAD_B) next_b = m_read(IR24_20);
            m_a = next_a;
            m_b = next_b;
        end
    end

    always @(negedge CLK) begin
        if (check_en) begin
            chk("rs1_data",    RS1_DATA,    m_read(IR19_15));
            chk("rs2_data",    RS2_DATA,    m_read(IR24_20));
            chk("dbg_data",    DBG_DATA,    m_read(DBG_ADDR));
            chk("reg_a_out",   REG_A_OUT,   m_a);
            chk("reg_b_out",   REG_B_OUT,   m_b);
            chk("write_count", {32'd0, WRITE_COUNT}, {32'd0, m_cnt});
        end
    end

    task automatic idle();
        BANCO_WIRE = 0; LOAD_A = 0; LOAD_B = 0; RESET = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [63:0] d);
        idle();
        BANCO_WIRE = 1; IR11_7 = rd; WRITE_DATA = d;
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle();
        RESET = 1;
        tick();
        RESET = 0;
    endtask

    initial begin
        idle();
        IR19_15 = 0; IR24_20 = 0; IR11_7 = 0; WRITE_DATA = 0; DBG_ADDR = 0;
        do_reset();
        check_en = 1'b1;
        chk("post_reset_count", {32'd0, WRITE_COUNT}, 64'd0);
        chk("post_reset_a", REG_A_OUT, 64'd0);

        // Reset clears registers, latches and the counter.
        BANCO_WIRE = 1; IR11_7 = 5; WRITE_DATA = 64'h1234; LOAD_A = 1; IR19_15 = 5;
        tick();
        idle();
        DBG_ADDR = 5; #1;
        chk("pre_reset_x5", DBG_DATA, 64'h1234);
        chk("pre_reset_a", REG_A_OUT, 64'h1234);
        do_reset(); #1;
        chk("reset_x5", DBG_DATA, 64'd0);
        chk("reset_a", REG_A_OUT, 64'd0);
        chk("reset_count", {32'd0, WRITE_COUNT}, 64'd0);

        // Write/read timing: old value during the write cycle, new value afterwards.
        BANCO_WIRE = 1; IR11_7 = 3; WRITE_DATA = 64'hDEAD_BEEF_0000_0001; IR19_15 = 3; #1;
        chk("rs1_during_write", RS1_DATA, 64'd0);
        tick();
        idle(); #1;
        chk("rs1_after_write", RS1_DATA, 64'hDEAD_BEEF_0000_0001);
        chk("count_after_write", {32'd0, WRITE_COUNT}, 64'd1);

        // x0 stays zero and does not count.
        wr(0, 64'hFFFF_FFFF_FFFF_FFFF);
        DBG_ADDR = 0; #1;
        chk("x0_read", DBG_DATA, 64'd0);
        chk("x0_count", {32'd0, WRITE_COUNT}, 64'd1);
        LOAD_A = 1; IR19_15 = 3; tick();
        chk("a_from_x3", REG_A_OUT, 64'hDEAD_BEEF_0000_0001);
        LOAD_A = 1; IR19_15 = 0; tick(); idle();
        chk("a_from_x0", REG_A_OUT, 64'd0);

        // Forwarding of a same-cycle write into both latches.
        wr(7, 64'h11);
        BANCO_WIRE = 1; IR11_7 = 7; WRITE_DATA = 64'h22;
        LOAD_A = 1; LOAD_B = 1; IR19_15 = 7; IR24_20 = 7;
        tick(); idle();
        chk("fwd_a", REG_A_OUT, 64'h22);
        chk("fwd_b", REG_B_OUT, 64'h22);

        // Independent latches.
        wr(1, 64'hA);
        wr(2, 64'hB);
        LOAD_A = 1; IR19_15 = 1; tick(); idle();
        chk("indep_a1", REG_A_OUT, 64'hA);
        chk("indep_b1", REG_B_OUT, 64'h22);
        LOAD_B = 1; IR24_20 = 2; tick(); idle();
        chk("indep_a2", REG_A_OUT, 64'hA);
        chk("indep_b2", REG_B_OUT, 64'hB);
        chk("indep_count", {32'd0, WRITE_COUNT}, 64'd5);

        // Full sweep from a clean reset.
        do_reset();
        for (int i = 1; i < 32; i++) wr(5'(i), 64'(i) * 64'h0101_0101_0101_0101);
        for (int i = 0; i < 32; i++) begin
            DBG_ADDR = 5'(i); #1;
            chk($sformatf("sweep_x%0d", i), DBG_DATA, 64'(i) * 64'h0101_0101_0101_0101);
        end
        chk("sweep_count", {32'd0, WRITE_COUNT}, 64'd31);

        // Randomized traffic; narrow address range half the time to provoke forwarding.
        for (int n = 0; n < 3000; n++) begin
            logic narrow;
            narrow     = ($urandom_range(0, 1) == 1);
            RESET      = ($urandom_range(0, 99) == 0);
            BANCO_WIRE = ($urandom_range(0, 2) != 0);
            LOAD_A     = $urandom_range(0, 1) == 1;
            LOAD_B     = $urandom_range(0, 1) == 1;
            IR11_7     = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
            IR19_15    = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
            IR24_20    = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
            DBG_ADDR   = 5'($urandom);
            WRITE_DATA = {$urandom, $urandom};
            tick();
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
